// File: rtl/asi_arb_if.sv
// Shared-memory arbitration bus between a write master, a read master and asi_arb.
// Request/grant: a side holds *request high while it has a burst pending. It may issue beats only while
// its grant is high, and it ends the burst with a beat carrying *last. The grant is held from the first beat to the last beat.
interface asi_arb_if;
    logic       usr_wrequest;
    logic       usr_we;
    logic       usr_wlast;
    logic       usr_wgrant;
    logic       usr_rrequest;
    logic       usr_re;
    logic       usr_rlast;
    logic       usr_rgrant;
    logic       usr_sel;
    logic       arb_busy;
    logic       arb_err;
    logic [1:0] state_dbg;
    logic [7:0] wait_w_dbg;
    logic [7:0] wait_r_dbg;

    modport master (
        output usr_wrequest, usr_we, usr_wlast, usr_rrequest, usr_re, usr_rlast,
        input  usr_wgrant, usr_rgrant, usr_sel, arb_busy, arb_err,
        input  state_dbg, wait_w_dbg, wait_r_dbg
    );

    modport slave (
        input  usr_wrequest, usr_we, usr_wlast, usr_rrequest, usr_re, usr_rlast,
        output usr_wgrant, usr_rgrant, usr_sel, arb_busy, arb_err,
        output state_dbg, wait_w_dbg, wait_r_dbg
    );
endinterface

// File: rtl/asi_arb.sv
// Write/read arbiter for a single-port user memory.
// It supports fixed priority or round-robin, a per-side anti-starvation counter and a sticky protocol error flag.
module asi_arb #(
    parameter int ARB_MODE = 0,
    parameter int MAX_WAIT = 16,
    parameter int CW       = $clog2(MAX_WAIT + 1)
) (
    input logic      usr_clk,
    input logic      usr_reset_n,
    asi_arb_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GNT_W = 2'b01,
        GNT_R = 2'b10
    } state_t;

    state_t        state;
    state_t        next_state;
    state_t        arb_next;
    logic          last_r;
    logic          beat_seen;
    logic          sel;
    logic          err;
    logic [CW-1:0] wait_w;
    logic [CW-1:0] wait_r;

    logic owner_last;
    logic early_drop;
    logic arb_point;
    logic starved_w;
    logic starved_r;
    logic pick_w;
    logic err_now;

    always_comb begin
        owner_last = 1'b0;
        early_drop = 1'b0;
        arb_point  = 1'b0;
        starved_w  = (wait_w == CW'(MAX_WAIT));
        starved_r  = (wait_r == CW'(MAX_WAIT));
        pick_w     = 1'b1;
        arb_next   = IDLE;
        next_state = state;

        owner_last = (state == GNT_W && bus.usr_we && bus.usr_wlast) ||
                     (state == GNT_R && bus.usr_re && bus.usr_rlast);
        // The owner may withdraw only before its first beat; after that the grant is locked.
        early_drop = !beat_seen &&
                     ((state == GNT_W && !bus.usr_wrequest && !bus.usr_we) ||
                      (state == GNT_R && !bus.usr_rrequest && !bus.usr_re));
        arb_point  = (state == IDLE) || owner_last || early_drop;

        if (starved_w && !starved_r) begin
            pick_w = 1'b1;
        end else if (starved_r && !starved_w) begin
            pick_w = 1'b0;
        end else if (ARB_MODE == 0) begin
            pick_w = 1'b1;
        end else if (ARB_MODE == 1) begin
            pick_w = 1'b0;
        end else begin
            pick_w = last_r;
        end

        if (bus.usr_wrequest && bus.usr_rrequest) begin
            arb_next = pick_w ? GNT_W : GNT_R;
        end else if (bus.usr_wrequest) begin
            arb_next = GNT_W;
        end else if (bus.usr_rrequest) begin
            arb_next = GNT_R;
        end else begin
            arb_next = IDLE;
        end

        case (state)
            IDLE, GNT_W, GNT_R: begin
                if (arb_point) begin
                    next_state = arb_next;
                end
            end
            default: next_state = IDLE;
        endcase

        err_now = (bus.usr_we && state != GNT_W) ||
                  (bus.usr_re && state != GNT_R) ||
                  (bus.usr_we && bus.usr_re);
    end

    always_ff @(posedge usr_clk or negedge usr_reset_n) begin
        if (!usr_reset_n) begin
            state     <= IDLE;
            last_r    <= 1'b1;
            beat_seen <= 1'b0;
            sel       <= 1'b0;
            err       <= 1'b0;
            wait_w    <= '0;
            wait_r    <= '0;
        end else begin
            state <= next_state;

            if (arb_point) begin
                beat_seen <= 1'b0;
            end else if ((state == GNT_W && bus.usr_we) || (state == GNT_R && bus.usr_re)) begin
                beat_seen <= 1'b1;
            end

            if (next_state == GNT_W) begin
                last_r <= 1'b0;
                sel    <= 1'b0;
            end else if (next_state == GNT_R) begin
                last_r <= 1'b1;
                sel    <= 1'b1;
            end

            if (next_state == GNT_W) begin
                wait_w <= '0;
            end else if (bus.usr_wrequest && state == GNT_R && !starved_w) begin
                wait_w <= wait_w + CW'(1);
            end

            if (next_state == GNT_R) begin
                wait_r <= '0;
            end else if (bus.usr_rrequest && state == GNT_W && !starved_r) begin
                wait_r <= wait_r + CW'(1);
            end

            if (err_now) begin
                err <= 1'b1;
            end
        end
    end

    assign bus.usr_wgrant = (state == GNT_W);
    assign bus.usr_rgrant = (state == GNT_R);
    assign bus.arb_busy   = (state != IDLE);
    assign bus.usr_sel    = sel;
    assign bus.arb_err    = err;
    assign bus.state_dbg  = state;
    assign bus.wait_w_dbg = 8'(wait_w);
    assign bus.wait_r_dbg = 8'(wait_r);

endmodule

// File: tb/tb_asi_arb.sv
// Directed bench for asi_arb: four instances (write priority, read priority, round-robin, short starvation threshold)
// share one stimulus stream, and each scenario checks the instance it targets.
module tb_asi_arb;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic wreq = 1'b0, we = 1'b0, wlast = 1'b0;
    logic rreq = 1'b0, re = 1'b0, rlast = 1'b0;
    int   n_total = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    asi_arb_if if_m0 ();
    asi_arb_if if_m1 ();
    asi_arb_if if_m2 ();
    asi_arb_if if_s ();

    assign if_m0.usr_wrequest = wreq;  assign if_m0.usr_we = we;  assign if_m0.usr_wlast = wlast;
    assign if_m0.usr_rrequest = rreq;  assign if_m0.usr_re = re;  assign if_m0.usr_rlast = rlast;
    assign if_m1.usr_wrequest = wreq;  assign if_m1.usr_we = we;  assign if_m1.usr_wlast = wlast;
    assign if_m1.usr_rrequest = rreq;  assign if_m1.usr_re = re;  assign if_m1.usr_rlast = rlast;
    assign if_m2.usr_wrequest = wreq;  assign if_m2.usr_we = we;  assign if_m2.usr_wlast = wlast;
    assign if_m2.usr_rrequest = rreq;  assign if_m2.usr_re = re;  assign if_m2.usr_rlast = rlast;
    assign if_s.usr_wrequest  = wreq;  assign if_s.usr_we  = we;  assign if_s.usr_wlast  = wlast;
    assign if_s.usr_rrequest  = rreq;  assign if_s.usr_re  = re;  assign if_s.usr_rlast  = rlast;

    asi_arb #(.ARB_MODE(0), .MAX_WAIT(16)) dut_m0 (.usr_clk(clk), .usr_reset_n(rst_n), .bus(if_m0));
    asi_arb #(.ARB_MODE(1), .MAX_WAIT(16)) dut_m1 (.usr_clk(clk), .usr_reset_n(rst_n), .bus(if_m1));
    asi_arb #(.ARB_MODE(2), .MAX_WAIT(16)) dut_m2 (.usr_clk(clk), .usr_reset_n(rst_n), .bus(if_m2));
    asi_arb #(.ARB_MODE(0), .MAX_WAIT(3))  dut_s  (.usr_clk(clk), .usr_reset_n(rst_n), .bus(if_s));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic wr, input logic w, input logic wl,
                         input logic rr, input logic r, input logic rl);
        wreq = wr; we = w; wlast = wl;
        rreq = rr; re = r; rlast = rl;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset values
        drive(0, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        tick();
        check("rst_wgnt",  32'(if_m0.usr_wgrant), 0);
        check("rst_rgnt",  32'(if_m0.usr_rgrant), 0);
        check("rst_sel",   32'(if_m0.usr_sel), 0);
        check("rst_busy",  32'(if_m0.arb_busy), 0);
        check("rst_err",   32'(if_m0.arb_err), 0);
        check("rst_state", 32'(if_m0.state_dbg), 0);
        check("rst_wait",  32'({if_m0.wait_w_dbg, if_m0.wait_r_dbg}), 0);
        tick();
        rst_n = 1'b1;

        // Tie in IDLE: each mode's winner
        drive(1, 0, 0, 1, 0, 0);
        tick();
        check("a_m0_wgnt", 32'(if_m0.usr_wgrant), 1);
        check("a_m0_rgnt", 32'(if_m0.usr_rgrant), 0);
        check("a_m0_sel",  32'(if_m0.usr_sel), 0);
        check("a_m1_rgnt", 32'(if_m1.usr_rgrant), 1);
        check("a_m1_sel",  32'(if_m1.usr_sel), 1);
        check("a_m2_wgnt", 32'(if_m2.usr_wgrant), 1);

        // 4-beat write with read pending: held, then handover with no bubble
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 1, 0, 0);
            tick();
            check("b_hold", 32'(if_m0.usr_wgrant), 1);
        end
        check("b_wait_r", 32'(if_m0.wait_r_dbg), 3);
        drive(0, 1, 1, 1, 0, 0);
        tick();
        check("b_hand_r",  32'(if_m0.usr_rgrant), 1);
        check("b_hand_w",  32'(if_m0.usr_wgrant), 0);
        check("b_busy",    32'(if_m0.arb_busy), 1);
        check("b_sel",     32'(if_m0.usr_sel), 1);
        check("b_wait_r0", 32'(if_m0.wait_r_dbg), 0);
        drive(0, 0, 0, 0, 1, 1);
        tick();
        check("b_idle",     32'(if_m0.arb_busy), 0);
        check("b_sel_hold", 32'(if_m0.usr_sel), 1);
        check("b_no_err",   32'(if_m0.arb_err), 0);

        // Round-robin with 1-beat bursts: W, R, W, R, W
        do_reset();
        drive(1, 0, 0, 1, 0, 0);
        tick();
        check("c_first_w", 32'(if_m2.usr_wgrant), 1);
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) drive(1, 1, 1, 1, 0, 0);
            else            drive(1, 0, 0, 1, 1, 1);
            tick();
            check("c_rr_rgnt", 32'(if_m2.usr_rgrant), (k % 2 == 0) ? 1 : 0);
            check("c_rr_wgnt", 32'(if_m2.usr_wgrant), (k % 2 == 0) ? 0 : 1);
        end

        // Starvation with MAX_WAIT=3 against back-to-back 2-beat writes
        do_reset();
        drive(1, 0, 0, 1, 0, 0);
        tick();
        check("d_wgnt",  32'(if_s.usr_wgrant), 1);
        check("d_wr_0",  32'(if_s.wait_r_dbg), 0);
        drive(1, 1, 0, 1, 0, 0);
        tick();
        check("d_wr_1",  32'(if_s.wait_r_dbg), 1);
        drive(1, 1, 1, 1, 0, 0);
        tick();
        check("d_w_again", 32'(if_s.usr_wgrant), 1);
        check("d_wr_2",  32'(if_s.wait_r_dbg), 2);
        drive(1, 1, 0, 1, 0, 0);
        tick();
        check("d_wr_3",  32'(if_s.wait_r_dbg), 3);
        drive(1, 1, 1, 1, 0, 0);
        tick();
        check("d_starve_r", 32'(if_s.usr_rgrant), 1);
        check("d_sel",      32'(if_s.usr_sel), 1);
        check("d_wr_clr",   32'(if_s.wait_r_dbg), 0);
        check("d_m0_keepw", 32'(if_m0.usr_wgrant), 1);
        check("d_m0_wr_4",  32'(if_m0.wait_r_dbg), 4);
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, 1, 1, 0);
            tick();
        end
        check("d_ww_sat",  32'(if_s.wait_w_dbg), 3);
        check("d_r_lock",  32'(if_s.usr_rgrant), 1);
        drive(1, 0, 0, 0, 1, 1);
        tick();
        check("d_w_back",  32'(if_s.usr_wgrant), 1);
        check("d_ww_clr",  32'(if_s.wait_w_dbg), 0);

        // Sticky error flag
        do_reset();
        check("e_clean", 32'(if_m0.arb_err), 0);
        drive(0, 0, 0, 0, 1, 0);
        tick();
        check("e_re_nogrant", 32'(if_m0.arb_err), 1);
        drive(0, 0, 0, 0, 0, 0);
        repeat (100) tick();
        check("e_sticky", 32'(if_m0.arb_err), 1);
        do_reset();
        check("e_cleared", 32'(if_m0.arb_err), 0);
        drive(0, 1, 0, 0, 0, 0);
        tick();
        check("e_we_nogrant", 32'(if_m0.arb_err), 1);

        // Lock after first beat beats read priority
        do_reset();
        drive(1, 0, 0, 0, 0, 0);
        tick();
        check("f_m1_wgnt", 32'(if_m1.usr_wgrant), 1);
        drive(1, 1, 0, 1, 0, 0);
        tick();
        check("f_m1_lock", 32'(if_m1.usr_wgrant), 1);
        drive(0, 1, 1, 1, 0, 0);
        tick();
        check("f_m1_hand", 32'(if_m1.usr_rgrant), 1);

        // Owner withdraws before its first beat: re-arbitrate
        do_reset();
        drive(0, 0, 0, 1, 0, 0);
        tick();
        check("f_m0_rgnt", 32'(if_m0.usr_rgrant), 1);
        drive(1, 0, 0, 0, 0, 0);
        tick();
        check("f_m0_rearb", 32'(if_m0.usr_wgrant), 1);

        // Reset during beat 2 of a read burst
        do_reset();
        drive(0, 0, 0, 1, 0, 0);
        tick();
        check("g_rgnt", 32'(if_m0.usr_rgrant), 1);
        drive(0, 0, 0, 1, 1, 0);
        tick();
        check("g_beat1", 32'(if_m0.usr_rgrant), 1);
        drive(0, 0, 0, 1, 1, 0);
        #2 rst_n = 1'b0;
        #1;
        check("g_async_rgnt", 32'(if_m0.usr_rgrant), 0);
        check("g_async_busy", 32'(if_m0.arb_busy), 0);
        drive(1, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b1;
        tick();
        check("g_fresh_w", 32'(if_m0.usr_wgrant), 1);
        check("g_err",     32'(if_m0.arb_err), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/asi_arb.md
ASI_ARB -- requirements
Module: asi_arb

Interface
REQ-001 The block SHALL be parameterised as follows, one per line: name, default, meaning.
- ARB_MODE, 0, 0 = write priority, 1 = read priority, 2 = round-robin.
- MAX_WAIT, 16, anti-starvation threshold in cycles; valid range 1..255.
- CW, $clog2(MAX_WAIT+1), wait-counter width (derived).

REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- usr_clk, in, 1, clock.
- usr_reset_n, in, 1, reset: asynchronous, active-low.
- usr_wrequest, in, 1, write side has a pending burst.
- usr_we, in, 1, write beat executed on the shared user memory.
- usr_wlast, in, 1, qualifies usr_we as the final beat of a write burst.
- usr_wgrant, out, 1, write side owns the memory.
- usr_rrequest, in, 1, read side has a pending burst.
- usr_re, in, 1, read beat executed.
- usr_rlast, in, 1, qualifies usr_re as the final beat of a read burst.
- usr_rgrant, out, 1, read side owns the memory.
- usr_sel, out, 1, memory mux select: 0 = write, 1 = read; holds its last value when idle.
- arb_busy, out, 1, a grant is active.
- arb_err, out, 1, sticky protocol-violation flag.

Function
REQ-003 The block SHALL implement a 3-state FSM: IDLE, GNT_W, GNT_R.
REQ-004 usr_wgrant SHALL equal (state==GNT_W), usr_rgrant SHALL equal (state==GNT_R), and arb_busy SHALL equal (state!=IDLE); all three are registered state decodes.
REQ-005 usr_wgrant and usr_rgrant SHALL never be high in the same cycle.
REQ-006 Arbitration point: state==IDLE, or the current owner's beat carries last (usr_we&&usr_wlast in GNT_W; usr_re&&usr_rlast in GNT_R).
REQ-007 At an arbitration point with no request, the next state SHALL be IDLE.
REQ-008 At an arbitration point with exactly one request, the next state SHALL be the grant for that requester.
REQ-009 At an arbitration point with both requests, the winner SHALL be selected as follows.
- The starved side (REQ-012) wins.
- Otherwise: ARB_MODE 0 selects write; ARB_MODE 1 selects read; ARB_MODE 2 selects the side not served last.
- The "last served" flag resets to read, so write wins the first tie.
REQ-010 Latency: a request asserted in IDLE at cycle n SHALL produce its grant at n+1. Back-to-back handover at a last beat in cycle n SHALL produce the new grant at n+1, with no idle bubble.
REQ-011 Lock and release:
- Once the owner performs its first beat, the grant SHALL be held until that owner's last beat, regardless of the other side's request.
- If the owner drops its request before its first beat, the FSM SHALL re-arbitrate in the following cycle.
REQ-012 Starvation counter: one CW-bit wait counter per side.
- Increments each cycle the side requests while the other side holds the grant.
- Saturates at MAX_WAIT.
- Clears to 0 in the cycle that side is granted.
- A side is starved when its counter equals MAX_WAIT.
- If both sides are starved, ARB_MODE decides.
REQ-013 usr_sel SHALL update to the new owner in the same cycle the grant rises.
REQ-014 arb_err SHALL set on any of the following and stay set until reset:
- usr_we without usr_wgrant;
- usr_re without usr_rgrant;
- usr_we and usr_re high in the same cycle.
REQ-015 An illegal state encoding SHALL return the FSM to IDLE on the next clock.

Reset
REQ-016 On usr_reset_n low, asynchronously: state = IDLE; usr_wgrant, usr_rgrant, usr_sel, arb_busy and arb_err = 0; both wait counters = 0; last-served flag = read.
REQ-017 A reset asserted mid-burst SHALL drop the grant immediately. After release, the FSM SHALL arbitrate afresh from IDLE on the first clock.

Verification
REQ-018 The bench SHALL cover the following directed scenarios.
- ARB_MODE=0, both requests high in IDLE -> usr_wgrant=1 next cycle, usr_sel=0, usr_rgrant=0.
- Write burst of 4 beats with rrequest high throughout -> write grant held for all 4 beats; usr_rgrant=1 the cycle after the beat with usr_wlast; no IDLE cycle between.
- ARB_MODE=2, both requests continuously, 1-beat bursts -> grants alternate W,R,W,R starting with W.
- ARB_MODE=0, MAX_WAIT=3, back-to-back write bursts of 2 beats, read requesting -> read wins the first arbitration point after its counter reaches 3, and its counter clears to 0.
- usr_re pulsed while usr_rgrant=0 -> arb_err=1 the next cycle, still 1 after 100 cycles, cleared only by usr_reset_n.
- usr_reset_n asserted during beat 2 of an 8-beat read -> usr_rgrant=0 asynchronously; after release with only wrequest high, usr_wgrant=1 after 1 clock.
